montgomery_mult: RTL and testbench

Radix-2, bit-serial Montgomery modular multiplier computing A·B·2^-WIDTH mod M. It is the first compute core behind the RSA command/data wrapper, which drives its operands from the 1024-bit data register and starts it on CMD_COMPUTE. The wrapper reads back a registered result on a one-cycle done pulse. One multiplication takes WIDTH+2 cycles from start to done.

---
 rtl/montgomery_mult_pkg.sv | 18 +
 rtl/montgomery_mult_mont_step.sv | 22 ++
 rtl/montgomery_mult.sv | 115 +++++++++++
 tb/tb_montgomery_mult.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_mult_pkg.sv
// Shared definitions for the RSA compute cores: default operand width and FSM state encoding.
package montgomery_mult_pkg;

    localparam int DEFAULT_WIDTH = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOP   = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Bit-counter width; guards the degenerate WIDTH=1 case of $clog2.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/montgomery_mult_mont_step.sv
// One radix-2 Montgomery iteration: (C + a_i*B + q*M) >> 1, q chosen to make the sum even.
// Kept on its own so the two-adder path can later be pipelined or swapped for carry-save.
module mont_step #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH+1:0] c_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic             a_bit_i,
    output logic [WIDTH+1:0] c_o
);

    logic [WIDTH+1:0] sum_ab;
    logic [WIDTH+1:0] sum_abm;

    always_comb begin
        sum_ab  = c_i + (a_bit_i ? {2'b00, b_i} : '0);
        sum_abm = sum_ab + (sum_ab[0] ? {2'b00, m_i} : '0);
        c_o     = sum_abm >> 1;
    end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M in WIDTH+2 cycles.
//  state  | meaning
//  IDLE   | waiting for start, operands captured on acceptance
//  LOOP   | one multiplier bit per cycle, WIDTH cycles
//  REDUCE | final conditional subtraction, result registered
//  DONE   | done pulse, start ignored
module montgomery_mult
    import montgomery_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH+1:0] c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH+1:0] step_c;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    mont_step #(.WIDTH(WIDTH)) u_step (
        .c_i     (c_q),
        .b_i     (b_q),
        .m_i     (m_q),
        .a_bit_i (a_q[0]),
        .c_o     (step_c)
    );

    // C < 2M here, so the top accumulator bit is zero and a WIDTH+1-bit compare suffices.
    always_comb begin
        diff   = {1'b0, c_q[WIDTH:0]} - {2'b00, m_q};
        borrow = diff[WIDTH+1];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    c_d     = '0;
                    cnt_d   = '0;
                    state_d = LOOP;
                end
            end
            LOOP: begin
                c_d   = step_c;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                result_d = WIDTH'(borrow ? c_q : diff);
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == LOOP) || (state_q == REDUCE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Bench for montgomery_mult: WIDTH=8 and WIDTH=1024 instances checked every cycle against an arithmetic model.
module tb_montgomery_mult;

    localparam int W8  = 8;
    localparam int W1K = 1024;

    logic clk;
    logic rst8_n, rst1k_n;
    logic start8, start1k;
    logic [W8-1:0]  a8, b8, m8, result8;
    logic [W1K-1:0] a1k, b1k, m1k, result1k;
    logic busy8, done8, busy1k, done1k;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    montgomery_mult #(.WIDTH(W8)) dut8 (
        .clk(clk), .resetn(rst8_n), .start(start8),
        .in_a(a8), .in_b(b8), .in_m(m8),
        .busy(busy8), .done(done8), .result(result8)
    );

    montgomery_mult #(.WIDTH(W1K)) dut1k (
        .clk(clk), .resetn(rst1k_n), .start(start1k),
        .in_a(a1k), .in_b(b1k), .in_m(m1k),
        .busy(busy1k), .done(done1k), .result(result1k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reduce A*B mod M, then divide by 2 modulo M (M odd) w times.
    function automatic logic [1023:0] mont_ref(input logic [1023:0] a, input logic [1023:0] b,
                                               input logic [1023:0] m, input int w);
        logic [2047:0] p;
        p = ({1024'b0, a} * {1024'b0, b}) % {1024'b0, m};
        for (int i = 0; i < w; i++)
            p = p[0] ? ((p + {1024'b0, m}) >> 1) : (p >> 1);
        return p[1023:0];
    endfunction

    function automatic logic [1023:0] rnd1k();
        logic [1023:0] r;
        for (int j = 0; j < 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (low 256 bits) at cycle %0d",
                     nm, act[255:0], exp[255:0], cyc);
        end
    endtask

    // Cycle-level expectation: phase = cycles since acceptance (0 = idle).
    int ph8 = 0, ph1k = 0;
    bit mvalid8 = 0, mvalid1k = 0;
    logic [1023:0] pend8, exp8, pend1k, exp1k;
    int acc_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst8_n) begin
            ph8 <= 0; exp8 <= '0; mvalid8 <= 1'b1;
        end else if (ph8 == 0) begin
            if (start8) begin
                ph8   <= 1;
                pend8 <= mont_ref({1016'b0, a8}, {1016'b0, b8}, {1016'b0, m8}, W8);
                acc_q.push_back(cyc);
            end
        end else if (ph8 == W8 + 1) begin
            ph8 <= W8 + 2; exp8 <= pend8;
        end else if (ph8 == W8 + 2) begin
            ph8 <= 0;
        end else begin
            ph8 <= ph8 + 1;
        end

        if (!rst1k_n) begin
            ph1k <= 0; exp1k <= '0; mvalid1k <= 1'b1;
        end else if (ph1k == 0) begin
            if (start1k) begin
                ph1k   <= 1;
                pend1k <= mont_ref(a1k, b1k, m1k, W1K);
            end
        end else if (ph1k == W1K + 1) begin
            ph1k <= W1K + 2; exp1k <= pend1k;
        end else if (ph1k == W1K + 2) begin
            ph1k <= 0;
        end else begin
            ph1k <= ph1k + 1;
        end
    end

    always @(negedge clk) begin
        if (mvalid8) begin
            chk("busy8",   {1023'b0, busy8}, {1023'b0, (ph8 >= 1 && ph8 <= W8 + 1)});
            chk("done8",   {1023'b0, done8}, {1023'b0, (ph8 == W8 + 2)});
            chk("result8", {1016'b0, result8}, exp8);
        end
        if (mvalid1k) begin
            chk("busy1k",   {1023'b0, busy1k}, {1023'b0, (ph1k >= 1 && ph1k <= W1K + 1)});
            chk("done1k",   {1023'b0, done1k}, {1023'b0, (ph1k == W1K + 2)});
            chk("result1k", result1k, exp1k);
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] expv, input string nm);
        int t0, lat, nbusy;
        bit seen;
        @(negedge clk);
        a8 = a; b8 = b; m8 = m; start8 = 1'b1; t0 = cyc;
        @(negedge clk);
        start8 = 1'b0;
        seen = 0; lat = -1; nbusy = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            if (done8) begin
                seen = 1; lat = cyc - t0;
            end else begin
                if (busy8) nbusy++;
                @(negedge clk);
            end
        end
        chk({nm, "_latency"}, 1024'(lat), 1024'(W8 + 2));
        chk({nm, "_busycycles"}, 1024'(nbusy), 1024'(W8 + 1));
        chk({nm, "_result"}, {1016'b0, result8}, {1016'b0, expv});
    endtask

    task automatic op1k(input logic [1023:0] a, input logic [1023:0] b, input logic [1023:0] m);
        int t0, lat;
        bit seen;
        logic [1023:0] e;
        e = mont_ref(a, b, m, W1K);
        @(negedge clk);
        a1k = a; b1k = b; m1k = m; start1k = 1'b1; t0 = cyc;
        @(negedge clk);
        start1k = 1'b0;
        seen = 0; lat = -1;
        for (int k = 0; k < 1100 && !seen; k++) begin
            if (done1k) begin
                seen = 1; lat = cyc - t0;
            end else begin
                @(negedge clk);
            end
        end
        chk("w1k_latency", 1024'(lat), 1024'(W1K + 2));
        chk("w1k_result", result1k, e);
    endtask

    initial begin
        int mlist[3];
        logic [1023:0] e, ra, rb, rm;
        mlist[0] = 239; mlist[1] = 255; mlist[2] = 129;
        rst8_n = 1'b0; rst1k_n = 1'b0; start8 = 1'b0; start1k = 1'b0;
        a8 = '0; b8 = '0; m8 = '0; a1k = '0; b1k = '0; m1k = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   {1023'b0, busy8},   1024'd0);
        chk("rst_done",   {1023'b0, done8},   1024'd0);
        chk("rst_result", {1016'b0, result8}, 1024'd0);
        chk("rst_result1k", result1k, 1024'd0);
        rst8_n = 1'b1; rst1k_n = 1'b1;

        chk("ref_5_7",   mont_ref(5, 7, 239, 8),     1024'd227);
        chk("ref_238",   mont_ref(238, 238, 239, 8), 1024'd225);
        chk("ref_ident", mont_ref(17, 1, 239, 8),    1024'd1);

        op8(8'd5,   8'd7,   8'd239, 8'd227, "basic");
        op8(8'd17,  8'd1,   8'd239, 8'd1,   "ident");
        op8(8'd0,   8'd200, 8'd239, 8'd0,   "zero");
        op8(8'd238, 8'd238, 8'd239, 8'd225, "max");

        for (int mi = 0; mi < 3; mi++) begin
            for (int a = 0; a < mlist[mi]; a += 11)
                for (int b = 0; b < mlist[mi]; b += 7) begin
                    e = mont_ref(1024'(a), 1024'(b), 1024'(mlist[mi]), W8);
                    op8(8'(a), 8'(b), 8'(mlist[mi]), e[7:0], "sweep");
                end
            e = mont_ref(1024'(mlist[mi] - 1), 1024'(mlist[mi] - 1), 1024'(mlist[mi]), W8);
            op8(8'(mlist[mi] - 1), 8'(mlist[mi] - 1), 8'(mlist[mi]), e[7:0], "sweep_top");
        end

        // Start held high; operands change while each multiplication runs.
        @(negedge clk);
        acc_q.delete();
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd239; start8 = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k == 5)  begin a8 = 8'd238; b8 = 8'd238; end
            if (k == 15) begin a8 = 8'd17;  b8 = 8'd1;   end
            if (k == 10) begin
                chk("held_done1", {1023'b0, done8}, 1024'd1);
                chk("held_res1", {1016'b0, result8}, 1024'd227);
            end
            if (k == 21) begin
                chk("held_done2", {1023'b0, done8}, 1024'd1);
                chk("held_res2", {1016'b0, result8}, 1024'd225);
            end
            if (k == 32) begin
                chk("held_done3", {1023'b0, done8}, 1024'd1);
                chk("held_res3", {1016'b0, result8}, 1024'd1);
                start8 = 1'b0;
            end
            if (k < 32) @(negedge clk);
        end
        chk("held_accepts", 1024'(acc_q.size()), 1024'd3);
        if (acc_q.size() == 3) begin
            chk("held_gap1", 1024'(acc_q[1] - acc_q[0]), 1024'd11);
            chk("held_gap2", 1024'(acc_q[2] - acc_q[1]), 1024'd11);
        end

        // Reset in LOOP iteration 4 (cycle 5 after acceptance).
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd239; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst8_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy",   {1023'b0, busy8},   1024'd0);
        chk("midrst_done",   {1023'b0, done8},   1024'd0);
        chk("midrst_result", {1016'b0, result8}, 1024'd0);
        rst8_n = 1'b1;
        op8(8'd5, 8'd7, 8'd239, 8'd227, "after_rst");

        for (int t = 0; t < 3; t++) begin
            rm = rnd1k();
            rm[1023] = 1'b1; rm[0] = 1'b1;
            ra = rnd1k() % rm;
            rb = rnd1k() % rm;
            op1k(ra, rb, rm);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
